// File: rtl/alu_sequencer.sv
// Instruction fetch/issue controller: fetches a 20-bit word plus up to two
// immediates over a req/ack handshake, then drives the ALU for a fixed window.
module alu_sequencer #(
   parameter int          EXEC_CYCLES = 2,
   parameter logic [19:0] RESET_PC    = 20'h00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [19:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [19:0] imem_rdata,
   output logic [4:0]  opcode,
   output logic [3:0]  dst_sel,
   output logic [3:0]  src1_sel,
   output logic [3:0]  src2_sel,
   output logic [19:0] src1_imm,
   output logic [19:0] src2_imm,
   output logic        enable,
   output logic        busy,
   output logic        halted
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_IMM1   = 3'd2;
   localparam logic [2:0] S_IMM2   = 3'd3;
   localparam logic [2:0] S_EXEC   = 3'd4;
   localparam logic [2:0] S_HALTED = 3'd5;

   localparam logic [4:0] OP_HALT   = 5'b11111;
   localparam logic [4:0] OP_JUMP   = 5'b01100;
   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [19:0] pc_q, pc_d;
   logic [19:0] ipc_q, ipc_d;
   logic [4:0]  opcode_q, opcode_d;
   logic [3:0]  dst_q, dst_d;
   logic [3:0]  src1_q, src1_d;
   logic [3:0]  src2_q, src2_d;
   logic [19:0] src1_imm_q, src1_imm_d;
   logic [19:0] src2_imm_q, src2_imm_d;
   logic [3:0]  cnt_q, cnt_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ipc_d      = ipc_q;
      opcode_d   = opcode_q;
      dst_d      = dst_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      src1_imm_d = src1_imm_q;
      src2_imm_d = src2_imm_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cnt_d = 4'd0;
            if (imem_ack) begin
               // Both immediates are cleared here; any that are fetched overwrite them.
               opcode_d   = imem_rdata[19:15];
               dst_d      = imem_rdata[14:11];
               src1_d     = imem_rdata[10:7];
               src2_d     = imem_rdata[6:3];
               src1_imm_d = 20'h00000;
               src2_imm_d = 20'h00000;
               ipc_d      = pc_q;
               pc_d       = pc_q + 20'd1;
               if (imem_rdata[19:15] == OP_HALT) begin
                  state_d = S_HALTED;
               end else if (imem_rdata[19]) begin
                  state_d = S_IMM1;
               end else if (imem_rdata[18]) begin
                  state_d = S_IMM2;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_IMM1: begin
            if (imem_ack) begin
               src1_imm_d = imem_rdata;
               pc_d       = pc_q + 20'd1;
               state_d    = opcode_q[3] ? S_IMM2 : S_EXEC;
            end
         end
         S_IMM2: begin
            if (imem_ack) begin
               src2_imm_d = imem_rdata;
               pc_d       = pc_q + 20'd1;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            if (opcode_q == OP_JUMP) begin
               pc_d    = ipc_q + src2_imm_q;
               state_d = S_FETCH;
            end else if (cnt_q == EXEC_LAST) begin
               cnt_d   = 4'd0;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ipc_q      <= RESET_PC;
         opcode_q   <= 5'd0;
         dst_q      <= 4'd0;
         src1_q     <= 4'd0;
         src2_q     <= 4'd0;
         src1_imm_q <= 20'h00000;
         src2_imm_q <= 20'h00000;
         cnt_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ipc_q      <= ipc_d;
         opcode_q   <= opcode_d;
         dst_q      <= dst_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         src1_imm_q <= src1_imm_d;
         src2_imm_q <= src2_imm_d;
         cnt_q      <= cnt_d;
      end
   end

   assign imem_addr = pc_q;
   assign imem_req  = (state_q == S_FETCH) || (state_q == S_IMM1) || (state_q == S_IMM2);
   assign opcode    = opcode_q;
   assign dst_sel   = dst_q;
   assign src1_sel  = src1_q;
   assign src2_sel  = src2_q;
   assign src1_imm  = src1_imm_q;
   assign src2_imm  = src2_imm_q;
   // A jump spends its single EXEC cycle updating the PC, never driving the ALU.
   assign enable    = (state_q == S_EXEC) && (opcode_q != OP_JUMP);
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a memory responder serves a directed
// program while monitors check fetch addresses and each enable window.
module tb_alu_sequencer;

   typedef struct packed {
      logic [4:0]  op;
      logic [3:0]  dst;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [19:0] imm1;
      logic [19:0] imm2;
   } exec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [19:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [19:0] imem_rdata;
   logic [4:0]  opcode;
   logic [3:0]  dst_sel, src1_sel, src2_sel;
   logic [19:0] src1_imm, src2_imm;
   logic        enable, busy, halted;

   logic        rst2, start2, ack2;
   logic [19:0] rdata2, addr2, imm1_2, imm2_2;
   logic        req2, enable2, busy2, halted2;
   logic [4:0]  opcode2;
   logic [3:0]  dst2, s1_2, s2_2;

   int          checks = 0;
   int          errors = 0;
   logic        hold_ack = 1'b0;
   logic [19:0] mem [logic [19:0]];
   exec_t       exp_q [$];
   logic [19:0] fetch_q [$];

   alu_sequencer #(.EXEC_CYCLES(2), .RESET_PC(20'h00000)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .opcode(opcode), .dst_sel(dst_sel), .src1_sel(src1_sel), .src2_sel(src2_sel),
      .src1_imm(src1_imm), .src2_imm(src2_imm),
      .enable(enable), .busy(busy), .halted(halted)
   );

   alu_sequencer #(.EXEC_CYCLES(2), .RESET_PC(20'hFFFFF)) dut_wrap (
      .clk(clk), .rst(rst2), .start(start2),
      .imem_addr(addr2), .imem_req(req2), .imem_ack(ack2), .imem_rdata(rdata2),
      .opcode(opcode2), .dst_sel(dst2), .src1_sel(s1_2), .src2_sel(s2_2),
      .src1_imm(imm1_2), .src2_imm(imm2_2),
      .enable(enable2), .busy(busy2), .halted(halted2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ack_delay(input logic [19:0] a);
      return (a == 20'd4 || a == 20'd5 || a == 20'd6) ? 3 : 0;
   endfunction

   // Memory responder: acks after a per-address delay and checks fetch order.
   initial begin
      int          wait_cnt;
      logic [19:0] wait_addr;
      wait_cnt   = 0;
      wait_addr  = 20'h0;
      imem_ack   = 1'b0;
      imem_rdata = 20'h0;
      forever begin
         @(negedge clk);
         if (rst || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end else if (hold_ack) begin
            imem_ack = 1'b0;
         end else begin
            if (wait_cnt == 0) wait_addr = imem_addr;
            else check_output("addr_hold", 64'(imem_addr), 64'(wait_addr));
            if (wait_cnt >= ack_delay(wait_addr)) begin
               imem_ack   = 1'b1;
               imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 20'h0;
               if (fetch_q.size() == 0) check_output("fetch_unexpected", 64'(imem_addr), 64'hFFFFFFFF);
               else check_output("fetch_addr", 64'(imem_addr), 64'(fetch_q.pop_front()));
               wait_cnt = 0;
            end else begin
               imem_ack = 1'b0;
               wait_cnt++;
            end
         end
      end
   end

   // Execute monitor: pops the expected instruction when enable rises.
   initial begin
      bit    in_win;
      int    win_len;
      exec_t cur;
      in_win  = 1'b0;
      win_len = 0;
      cur     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_win  = 1'b0;
            win_len = 0;
         end else if (enable) begin
            if (!in_win) begin
               in_win  = 1'b1;
               win_len = 0;
               if (exp_q.size() == 0) begin
                  check_output("unexpected_enable", 64'd1, 64'd0);
                  cur = '0;
               end else begin
                  cur = exp_q.pop_front();
               end
            end
            win_len++;
            check_output("exec_fields",
                         64'({opcode, dst_sel, src1_sel, src2_sel, src1_imm, src2_imm}), 64'(cur));
         end else if (in_win) begin
            in_win = 1'b0;
            check_output("enable_len", 64'(win_len), 64'd2);
            check_output("req_after_exec", 64'(imem_req), 64'd1);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halted(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (halted) return;
      end
      check_output("halt_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_enable"}, 64'(enable), 64'd0);
      check_output({tag, "_req"}, 64'(imem_req), 64'd0);
      check_output({tag, "_busy_halted"}, 64'({busy, halted}), 64'd0);
      check_output({tag, "_addr"}, 64'(imem_addr), 64'd0);
      check_output({tag, "_fields"}, 64'({opcode, dst_sel, src1_sel, src2_sel, src1_imm, src2_imm}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      mem[20'd0]  = 20'h00A98;
      mem[20'd1]  = 20'hF8000;
      mem[20'd2]  = 20'h12338;
      mem[20'd3]  = 20'h37848;
      mem[20'd4]  = 20'hC11A0;
      mem[20'd5]  = 20'h12345;
      mem[20'd6]  = 20'hABCDE;
      mem[20'd7]  = 20'h60000;
      mem[20'd8]  = 20'h00003;
      mem[20'd9]  = 20'hF8000;
      mem[20'd10] = 20'h60000;
      mem[20'd11] = 20'hFFFFE;

      rst = 1'b0; rst2 = 1'b0; start = 1'b0; start2 = 1'b0; ack2 = 1'b0; rdata2 = 20'h0;
      #1 rst = 1'b1; rst2 = 1'b1;
      #11;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // First instruction then HALT at address 1.
      fetch_q.push_back(20'd0);
      fetch_q.push_back(20'd1);
      exp_q.push_back('{5'd0, 4'd1, 4'd5, 4'd3, 20'h0, 20'h0});
      pulse_start();
      wait_halted(100);
      check_output("halt_flags", 64'({halted, busy, imem_req, enable}), 64'b1000);
      check_output("halt_next_pc", 64'(imem_addr), 64'd2);

      // Resume after HALT: two plain ops, two-immediate op, two jumps, HALT.
      foreach (mem[a]) if (a >= 20'd2 && a <= 20'd8) fetch_q.push_back(a);
      fetch_q.push_back(20'd10);
      fetch_q.push_back(20'd11);
      fetch_q.push_back(20'd8);
      fetch_q.push_back(20'd9);
      exp_q.push_back('{5'd2,  4'd4,  4'd6, 4'd7, 20'h0, 20'h0});
      exp_q.push_back('{5'd6,  4'd15, 4'd0, 4'd9, 20'h0, 20'h0});
      exp_q.push_back('{5'd24, 4'd2,  4'd3, 4'd4, 20'h12345, 20'hABCDE});
      exp_q.push_back('{5'd0,  4'd0,  4'd0, 4'd0, 20'h0, 20'h0});
      pulse_start();
      wait_halted(300);
      check_output("halt2_flags", 64'({halted, busy, imem_req, enable}), 64'b1000);
      check_output("halt2_next_pc", 64'(imem_addr), 64'd10);

      // Reset while enable is high.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      fetch_q.push_back(20'd0);
      exp_q.push_back('{5'd0, 4'd1, 4'd5, 4'd3, 20'h0, 20'h0});
      pulse_start();
      n = 0;
      while (!enable && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output("enable_seen", 64'(enable), 64'd1);
      #2 rst = 1'b1;
      #1 check_reset_state("rst_exec");
      @(negedge clk);
      #1 rst = 1'b0;

      // Reset while a fetch waits for ack.
      hold_ack = 1'b1;
      pulse_start();
      repeat (3) @(negedge clk);
      check_output("fetch_wait_req", 64'({imem_req, imem_addr}), 64'({1'b1, 20'd0}));
      #2 rst = 1'b1;
      #1 check_reset_state("rst_fetch");
      @(negedge clk);
      #1 rst = 1'b0;
      hold_ack = 1'b0;
      repeat (2) @(negedge clk);
      check_output("idle_after_rst", 64'({busy, imem_req}), 64'd0);

      // PC wrap on the second instance.
      check_output("wrap_reset_pc", 64'(addr2), 64'hFFFFF);
      @(negedge clk); rst2 = 1'b0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      check_output("wrap_fetch", 64'({req2, addr2}), 64'({1'b1, 20'hFFFFF}));
      ack2 = 1'b1; rdata2 = 20'h08000;
      @(negedge clk); ack2 = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (enable2) n++;
         else if (n > 0) break;
         @(negedge clk);
      end
      check_output("wrap_enable_len", 64'(n), 64'd2);
      check_output("wrap_opcode", 64'(opcode2), 64'd1);
      check_output("wrap_next", 64'({req2, addr2}), 64'({1'b1, 20'd0}));

      check_output("exec_queue_empty", 64'(exp_q.size()), 64'd0);
      check_output("fetch_queue_empty", 64'(fetch_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
